mlp_event_dispatcher: RTL and testbench



---
 rtl/mlp_denoiser_pkg.sv | 23 ++
 rtl/mlp_event_dispatcher_if.sv | 26 ++
 rtl/mlp_evt_fifo.sv | 54 +++++
 rtl/mlp_event_dispatcher.sv | 144 ++++++++++++++
 tb/tb_mlp_event_dispatcher.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_denoiser_pkg.sv
// Shared types and constants for the MLP denoiser front end: CAVIAR event
// layout, default sensor geometry and the dispatcher state encoding.
package mlp_denoiser_pkg;

  localparam int CAVIAR_X_Y_BITS = 9;
  localparam int TIMESTAMP_BITS  = 16;
  localparam int CAVIAR_EVT_BITS = 2 * CAVIAR_X_Y_BITS + 1;
  localparam int DVS_WIDTH_DEF   = 346;
  localparam int DVS_HEIGHT_DEF  = 260;

  typedef struct packed {
    logic [CAVIAR_X_Y_BITS-1:0] x;
    logic [CAVIAR_X_Y_BITS-1:0] y;
    logic                       pol;
  } caviar_evt_t;

  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_ISSUE = 2'd1,
    DISP_BUSY  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/mlp_event_dispatcher_if.sv
// Event stream and builder handshake bundle for mlp_event_dispatcher.
// slave = dispatcher side, master = producer/builder side.
interface mlp_event_dispatcher_if #(
  parameter int XY_BITS = 9,
  parameter int TS_BITS = 16
);
  logic [2*XY_BITS:0] evt_in;
  logic [TS_BITS-1:0] evt_ts;
  logic               evt_vld;
  logic               evt_rdy;
  logic [2*XY_BITS:0] cavier_out;
  logic               cavier_out_vld;
  logic [TS_BITS-1:0] ts_out;
  logic               ts_out_vld;
  logic               builder_done;

  modport slave (
    input  evt_in, evt_ts, evt_vld, builder_done,
    output evt_rdy, cavier_out, cavier_out_vld, ts_out, ts_out_vld
  );

  modport master (
    output evt_in, evt_ts, evt_vld, builder_done,
    input  evt_rdy, cavier_out, cavier_out_vld, ts_out, ts_out_vld
  );
endinterface

// File: rtl/mlp_evt_fifo.sv
// Synchronous show-ahead FIFO for dispatcher events; head is valid while
// not empty. DEPTH must be a power of two >= 2.
module mlp_evt_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (cnt_q == (AW+1)'(DEPTH));
    empty    = (cnt_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/mlp_event_dispatcher.sv
// Buffers in-range CAVIAR events and issues them one at a time to the MLP
// activation builder. Optional builder watchdog: MLP_DISPATCH_TIMEOUT_EN.
module mlp_event_dispatcher
  import mlp_denoiser_pkg::*;
#(
  parameter int DVS_WIDTH       = DVS_WIDTH_DEF,
  parameter int DVS_HEIGHT      = DVS_HEIGHT_DEF,
  parameter int CAVIAR_X_Y_BITS = mlp_denoiser_pkg::CAVIAR_X_Y_BITS,
  parameter int TIMESTAMP_BITS  = mlp_denoiser_pkg::TIMESTAMP_BITS,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  mlp_event_dispatcher_if.slave   bus,
  output logic                    busy,
  output logic [15:0]             bad_cnt,
  output logic [15:0]             proc_cnt,
  output logic                    timeout_err
);
  localparam int B  = CAVIAR_X_Y_BITS;
  localparam int EW = 2 * B + 1;
  localparam int FW = EW + TIMESTAMP_BITS;

  disp_state_t state_q, state_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic [15:0] proc_cnt_q, proc_cnt_d;

  logic [B-1:0] in_x, in_y;
  logic         in_range, xfer, push, pop, done_ok, tmo_hit;
  logic [FW-1:0] fifo_head;
  logic          fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic          fifo_count_unused;

  assign in_x     = bus.evt_in[2*B:B+1];
  assign in_y     = bus.evt_in[B:1];
  assign in_range = (int'(in_x) < DVS_WIDTH) && (int'(in_y) < DVS_HEIGHT);
  assign xfer     = bus.evt_vld && bus.evt_rdy;
  assign push     = xfer && in_range;

  mlp_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.evt_in, bus.evt_ts}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_count_unused = ^fifo_count;
  assign bus.evt_rdy       = !fifo_full;

`ifdef MLP_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q;

  // Counter is zero on the first BUSY cycle, so the limit is hit after
  // exactly TIMEOUT_CYCLES cycles spent waiting.
  assign wd_cnt_d = (state_q == DISP_BUSY) ? wd_cnt_q + WD_W'(1) : '0;
  assign tmo_hit  = (state_q == DISP_BUSY) && !bus.builder_done &&
                    (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= tmo_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic [31:0] timeout_cycles_unused;
  assign timeout_cycles_unused = TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    pop                = 1'b0;
    done_ok            = 1'b0;
    bus.cavier_out_vld = 1'b0;
    bus.ts_out_vld     = 1'b0;
    bus.cavier_out     = '0;
    bus.ts_out         = '0;
    unique case (state_q)
      DISP_IDLE: begin
        if (!fifo_empty && enable) state_d = DISP_ISSUE;
      end
      DISP_ISSUE: begin
        pop                = 1'b1;
        bus.cavier_out_vld = 1'b1;
        bus.ts_out_vld     = 1'b1;
        bus.cavier_out     = fifo_head[FW-1:TIMESTAMP_BITS];
        bus.ts_out         = fifo_head[TIMESTAMP_BITS-1:0];
        state_d            = DISP_BUSY;
      end
      DISP_BUSY: begin
        if (bus.builder_done) begin
          done_ok = 1'b1;
          state_d = DISP_IDLE;
        end else if (tmo_hit) begin
          state_d = DISP_IDLE;
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  always_comb begin
    bad_cnt_d  = bad_cnt_q;
    if (xfer && !in_range && (bad_cnt_q != '1)) bad_cnt_d = bad_cnt_q + 16'd1;
    proc_cnt_d = proc_cnt_q + 16'(done_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DISP_IDLE;
      bad_cnt_q  <= '0;
      proc_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bad_cnt_q  <= bad_cnt_d;
      proc_cnt_q <= proc_cnt_d;
    end
  end

  assign busy     = (state_q != DISP_IDLE);
  assign bad_cnt  = bad_cnt_q;
  assign proc_cnt = proc_cnt_q;

endmodule

// File: tb/tb_mlp_event_dispatcher.sv
// Scoreboard bench for mlp_event_dispatcher: stimulus queues expected issues,
// a negedge monitor pops and compares them.
module tb_mlp_event_dispatcher;
  import mlp_denoiser_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        busy, timeout_err;
  logic [15:0] bad_cnt, proc_cnt;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    logic [18:0] ev;
    logic [15:0] ts;
    int          cyc;
  } exp_t;
  exp_t expq[$];

  mlp_event_dispatcher_if #(.XY_BITS(9), .TS_BITS(16)) bus ();

  mlp_event_dispatcher #(
    .DVS_WIDTH      (346),
    .DVS_HEIGHT     (260),
    .CAVIAR_X_Y_BITS(9),
    .TIMESTAMP_BITS (16),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus.slave),
    .busy       (busy),
    .bad_cnt    (bad_cnt),
    .proc_cnt   (proc_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat < 0: issue cycle not checked
  task automatic send(input int x, input int y, input bit pol, input logic [15:0] ts,
                      input bit expect_issue, input int lat);
    caviar_evt_t e;
    int n = 0;
    while (!bus.evt_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!bus.evt_rdy) begin
      chk("evt_rdy_wait", 0, 1);
    end else begin
      e.x = 9'(x);
      e.y = 9'(y);
      e.pol = pol;
      bus.evt_in  = e;
      bus.evt_ts  = ts;
      bus.evt_vld = 1'b1;
      if (expect_issue) expq.push_back('{ev: e, ts: ts, cyc: (lat < 0) ? -1 : cyc + lat});
      tick();
      bus.evt_vld = 1'b0;
    end
  endtask

  task automatic pulse_done();
    bus.builder_done = 1'b1;
    tick();
    bus.builder_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ts_vld_eq_vld", bus.ts_out_vld, bus.cavier_out_vld);
`ifndef MLP_DISPATCH_TIMEOUT_EN
      chk("timeout_err_low", timeout_err, 0);
`endif
      if (bus.cavier_out_vld) begin
        if (expq.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("issue_evt", bus.cavier_out, e.ev);
          chk("issue_ts", bus.ts_out, e.ts);
          if (e.cyc >= 0) chk("issue_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_data_zero", {bus.cavier_out, bus.ts_out}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.evt_in = '0;
    bus.evt_ts = '0;
    bus.evt_vld = 1'b0;
    bus.builder_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    chk("rst_evt_rdy", bus.evt_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_vld", bus.cavier_out_vld, 0);
    chk("rst_cavier_out", bus.cavier_out, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
    chk("rst_proc_cnt", proc_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // single event, issue at t+2, busy until done
    send(10, 20, 1'b1, 16'h1234, 1'b1, 2);
    tick();
    chk("single_busy_issue", busy, 1);
    tick();
    chk("single_busy_wait", busy, 1);
    repeat (5) tick();
    chk("single_busy_hold", busy, 1);
    pulse_done();
    chk("single_busy_done", busy, 0);
    chk("single_proc_cnt", proc_cnt, 1);

    // fill FIFO with issue held off, then drain in order
    enable = 1'b0;
    for (int i = 0; i < 8; i++) send(i + 1, i + 2, i[0], 16'(16'hA000 + i), 1'b1, -1);
    chk("full_evt_rdy_low", bus.evt_rdy, 0);
    chk("full_busy_low", busy, 0);
    enable = 1'b1;
    tick();
    chk("full_first_issue", bus.cavier_out_vld, 1);
    chk("full_rdy_same_cycle", bus.evt_rdy, 0);
    tick();
    chk("full_rdy_after_pop", bus.evt_rdy, 1);
    for (int i = 1; i < 8; i++) begin
      pulse_done();
      tick();
      chk("drain_issue_d2", bus.cavier_out_vld, 1);
      tick();
    end
    pulse_done();
    chk("drain_done_busy", busy, 0);
    chk("drain_proc_cnt", proc_cnt, 9);

    // out-of-range events and boundary in-range event
    send(346, 5, 1'b0, 16'h0001, 1'b0, -1);
    send(5, 260, 1'b1, 16'h0002, 1'b0, -1);
    chk("bad_cnt_two", bad_cnt, 2);
    chk("bad_no_busy", busy, 0);
    send(345, 259, 1'b0, 16'hBEEF, 1'b1, 2);
    tick();
    bus.builder_done = 1'b1;
    tick();
    bus.builder_done = 1'b0;
    chk("done_in_issue_busy", busy, 1);
    chk("done_in_issue_proc", proc_cnt, 9);
    pulse_done();
    chk("edge_evt_proc", proc_cnt, 10);

    // bad_cnt saturation
    force dut.bad_cnt_q = 16'hFFFD;
    tick();
    release dut.bad_cnt_q;
    chk("bad_preset", bad_cnt, 16'hFFFD);
    send(400, 0, 1'b0, 16'h0, 1'b0, -1);
    chk("bad_fffe", bad_cnt, 16'hFFFE);
    send(0, 300, 1'b0, 16'h0, 1'b0, -1);
    chk("bad_ffff", bad_cnt, 16'hFFFF);
    send(511, 511, 1'b1, 16'h0, 1'b0, -1);
    chk("bad_saturate", bad_cnt, 16'hFFFF);

    // enable gating and back-to-back done timing
    enable = 1'b0;
    send(1, 1, 1'b1, 16'h1111, 1'b1, -1);
    send(2, 2, 1'b0, 16'h2222, 1'b1, -1);
    send(3, 3, 1'b1, 16'h3333, 1'b1, -1);
    repeat (3) tick();
    chk("disabled_no_busy", busy, 0);
    enable = 1'b1;
    tick();
    chk("enable_issue_1cyc", bus.cavier_out_vld, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      pulse_done();
      tick();
      chk("b2b_issue_d2", bus.cavier_out_vld, 1);
      tick();
    end
    pulse_done();
    chk("b2b_idle", busy, 0);
    chk("b2b_proc_cnt", proc_cnt, 13);

    // reset during BUSY flushes, late done ignored
    send(7, 8, 1'b0, 16'h7777, 1'b1, 2);
    send(9, 9, 1'b1, 16'h9999, 1'b1, -1);
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expq.delete();
    chk("post_rst_rdy", bus.evt_rdy, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_proc", proc_cnt, 0);
    chk("post_rst_bad", bad_cnt, 0);
    pulse_done();
    tick();
    chk("late_done_proc", proc_cnt, 0);
    chk("late_done_busy", busy, 0);
    repeat (4) tick();

    // builder never answers
    send(100, 100, 1'b1, 16'h4242, 1'b1, 2);
`ifdef MLP_DISPATCH_TIMEOUT_EN
    begin
      int pulses = 0;
      for (int i = 0; i < 80; i++) begin
        tick();
        if (timeout_err) pulses++;
      end
      chk("timeout_pulses", pulses, 1);
      chk("timeout_idle", busy, 0);
      chk("timeout_proc", proc_cnt, 0);
    end
`else
    repeat (1000) tick();
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_proc", proc_cnt, 0);
    pulse_done();
    chk("no_timeout_done_proc", proc_cnt, 1);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
